pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS-32 datapath.
- Decides each cycle whether PC and IF/ID advance, whether a bubble is injected into ID/EX, and whether IF/ID is flushed.
- Handles load-use stalls, taken-branch flush, memory-wait freeze, and a HALT drain/resume sequence.
- Sits beside the datapath; its enables gate the pipeline-register updates on the datapath clock.

---
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: MIPS-32 stall/flush/halt sequencer (HAZ_PERF_EN adds stall/flush/wait counters)
module pipe_hazard_ctrl #(
  parameter int BR_PENALTY  = 2,
  parameter int DRAIN_DEPTH = 3
`ifdef HAZ_PERF_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_halt,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_branch_taken,
  input  logic       mem_wait,
  input  logic       resume,
  output logic       pc_en,
  output logic       pc_sel_branch,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       freeze,
  output logic       halted
`ifdef HAZ_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);
  localparam int MAXP = BR_PENALTY > DRAIN_DEPTH ? BR_PENALTY : DRAIN_DEPTH;
  localparam int CW = $clog2(MAXP + 1);
  localparam logic [CW-1:0] BR_RELOAD = CW'(BR_PENALTY - 1);
  localparam logic [CW-1:0] DR_RELOAD = CW'(DRAIN_DEPTH - 1);
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lu;
  assign lu = ex_is_load && ex_rd != 5'd0 &&
              ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
  // State and remaining-cycle counter; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Next state and enables; priority mem_wait > branch > load-use > halt
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    freeze        = 1'b0;
    halted        = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      cnt_d        = '0;
    end else if (mem_wait) begin
      freeze   = 1'b1;
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      halted   = state_q == HALTED;
    end else if (ex_branch_taken && state_q != HALTED) begin
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      state_d       = BR_PENALTY > 1 ? FLUSH : RUN;
      cnt_d         = BR_PENALTY > 1 ? BR_RELOAD : '0;
    end else begin
      case (state_q)
        RUN: begin
          if (lu || id_is_halt) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
          if (!lu && id_is_halt) begin
            state_d = DRAIN_DEPTH > 1 ? DRAIN : HALTED;
            cnt_d   = DRAIN_DEPTH > 1 ? DR_RELOAD : '0;
          end
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - 1'b1;
          state_d      = cnt_q <= CW'(1) ? RUN : FLUSH;
        end
        DRAIN: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - 1'b1;
          state_d      = cnt_q <= CW'(1) ? HALTED : DRAIN;
        end
        HALTED: begin
          halted       = 1'b1;
          pc_en        = resume;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          if_id_flush  = resume;
          state_d      = resume ? RUN : HALTED;
        end
      endcase
    end
  end
`ifdef HAZ_PERF_EN
  logic stall_ev;
  assign stall_ev = state_q == RUN && !mem_wait && !ex_branch_taken && lu;
  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_ev && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      if (mem_wait && !(&wait_cnt)) wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with a cycle model of the hazard controller
module tb_pipe_hazard_ctrl;
  localparam int BRP = 2;
  localparam int DD = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_uses_rs, id_uses_rt, id_is_halt, ex_is_load, ex_branch_taken, mem_wait, resume;
  logic pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_bubble, freeze, halted;
  int compared = 0;
  int mismatched = 0;
`ifdef HAZ_PERF_EN
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
  int m_stall = 0, m_flush = 0, m_wait = 0;
`endif

  pipe_hazard_ctrl #(.BR_PENALTY(BRP), .DRAIN_DEPTH(DD)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_is_halt(id_is_halt), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait), .resume(resume), .pc_en(pc_en),
    .pc_sel_branch(pc_sel_branch), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .freeze(freeze), .halted(halted)
`ifdef HAZ_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: remaining flush cycles, remaining drain cycles, halted flag
  int m_fl = 0, m_dl = 0;
  bit m_h = 0;

  function automatic bit load_use();
    if (!ex_is_load || ex_rd == 0) return 0;
    return (id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt);
  endfunction

  // Per-cycle compare against the model; outputs packed as
  // {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_bubble, freeze, halted}
  always @(negedge clk) begin : cmp
    logic [6:0] e;
    bit stall;
    stall = 0;
    if (!rst_n) begin
      e = 7'b0001100;
      m_fl = 0; m_dl = 0; m_h = 0;
    end else if (mem_wait) begin
      e = {6'b000001, m_h};
    end else if (ex_branch_taken && !m_h) begin
      e = 7'b1111100;
      m_fl = BRP - 1; m_dl = 0;
    end else if (m_fl > 0) begin
      e = 7'b1011100;
      m_fl--;
    end else if (m_dl > 0) begin
      e = 7'b0000100;
      m_dl--;
      if (m_dl == 0) m_h = 1;
    end else if (m_h) begin
      e = resume ? 7'b1001101 : 7'b0000101;
      if (resume) m_h = 0;
    end else if (load_use()) begin
      e = 7'b0000100;
      stall = 1;
    end else if (id_is_halt) begin
      e = 7'b0000100;
      m_dl = DD - 1;
      if (m_dl == 0) m_h = 1;
    end else begin
      e = 7'b1010000;
    end
    chk("outs", {25'd0, pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_bubble, freeze, halted}, {25'd0, e});
`ifdef HAZ_PERF_EN
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
    chk("flush_cnt", {16'd0, flush_cnt}, m_flush);
    chk("wait_cnt", {16'd0, wait_cnt}, m_wait);
    if (!rst_n) begin
      m_stall = 0; m_flush = 0; m_wait = 0;
    end else begin
      m_stall += stall;
      m_flush += e[3];
      m_wait += mem_wait;
    end
`else
    if (stall) e[0] = e[0];
`endif
  end

  task automatic idle();
    {id_rs, id_rt, ex_rd} = '0;
    {id_uses_rs, id_uses_rt, id_is_halt, ex_is_load, ex_branch_taken, mem_wait, resume} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    tick(); tick();
    #2;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_flush", if_id_flush, 1);
    chk("rst_bubble", id_ex_bubble, 1);
    tick();
    rst_n = 1'b1;
    #2 chk("run_pc_en", pc_en, 1);
    tick();
    // load-use on rs, one cycle
    ex_is_load = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    #2 chk("lu_pc_en", pc_en, 0);
    chk("lu_bubble", id_ex_bubble, 1);
    tick();
    ex_is_load = 0;
    #2 chk("lu_after", pc_en, 1);
    tick();
    // ex_rd = 0 never stalls
    ex_is_load = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    #2 chk("lu_r0", pc_en, 1);
    tick();
    // load-use on rt, then rt not read
    ex_rd = 7; id_rt = 7; id_uses_rs = 0; id_uses_rt = 1;
    #2 chk("lu_rt", if_id_en, 0);
    tick();
    id_uses_rt = 0;
    #2 chk("lu_rt_unused", if_id_en, 1);
    tick();
    idle();
    // branch pulse
    ex_branch_taken = 1;
    #2 chk("br0_sel", pc_sel_branch, 1);
    chk("br0_flush", if_id_flush, 1);
    tick();
    ex_branch_taken = 0;
    #2 chk("br1_flush", if_id_flush, 1);
    chk("br1_sel", pc_sel_branch, 0);
    tick();
    #2 chk("br2_flush", if_id_flush, 0);
    tick();
    // branch with load-use: branch wins
    ex_branch_taken = 1; ex_is_load = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
    #2 chk("brlu_pc_en", pc_en, 1);
    chk("brlu_sel", pc_sel_branch, 1);
    tick();
    idle();
    tick(); tick();
    // halt drain and resume
    id_is_halt = 1;
    #2 chk("h0_bubble", id_ex_bubble, 1);
    tick();
    id_is_halt = 0;
    tick();
    #2 chk("h2_halted", halted, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      #2 chk("halted_hold", halted, 1);
      tick();
    end
    mem_wait = 1;
    #2 chk("halt_wait_h", halted, 1);
    chk("halt_wait_fz", freeze, 1);
    tick();
    mem_wait = 0; resume = 1;
    #2 chk("res_flush", if_id_flush, 1);
    chk("res_pc_en", pc_en, 1);
    tick();
    resume = 0;
    #2 chk("res_halted", halted, 0);
    tick();
    // mem_wait mid-flush
    ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0; mem_wait = 1;
    for (int i = 0; i < 4; i++) begin
      #2 chk("mw_freeze", freeze, 1);
      chk("mw_pc_en", pc_en, 0);
      tick();
    end
    mem_wait = 0;
    #2 chk("mw_rem_flush", if_id_flush, 1);
    tick();
    #2 chk("mw_run", if_id_flush, 0);
    tick();
    // branch during drain abandons halt
    id_is_halt = 1;
    tick();
    id_is_halt = 0; ex_branch_taken = 1;
    #2 chk("dbr_sel", pc_sel_branch, 1);
    tick();
    ex_branch_taken = 0;
    for (int i = 0; i < 6; i++) begin
      #2 chk("dbr_nohalt", halted, 0);
      tick();
    end
    // async reset mid-drain
    id_is_halt = 1;
    tick();
    id_is_halt = 0;
    #2 rst_n = 0;
    #1 chk("arst_pc_en", pc_en, 0);
    chk("arst_flush", if_id_flush, 1);
    chk("arst_bubble", id_ex_bubble, 1);
    tick(); tick();
    rst_n = 1;
    #2 chk("arst_rel_pc", pc_en, 1);
    chk("arst_rel_halt", halted, 0);
    tick(); tick(); tick(); tick();
    #2 chk("arst_no_halt", halted, 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
